c432_irq_sched: RTL

Sequential interrupt scheduler wrapped around the combinational ISCAS-85 c432 27-channel priority core. It holds sticky pending requests for three 9-channel buses (A, B, C) and snapshots them with the per-channel enables. It drives the snapshot into one c432 instance, waits a fixed settle time, and registers the winning bus and channel. It then raises an interrupt and clears the served pending bit on CPU acknowledge.

---
 rtl/c432_sched_pkg.sv | 31 +++
 rtl/c432.sv | 45 ++++
 rtl/c432_irq_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/c432_sched_pkg.sv
// Shared types and constants for the c432 interrupt scheduler.
package c432_sched_pkg;

    localparam int unsigned NCH    = 9;
    localparam int unsigned CHAN_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BUS_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        SIGNAL = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam logic [BUS_W-1:0] BUS_NONE = 2'd0;
    localparam logic [BUS_W-1:0] BUS_A    = 2'd1;
    localparam logic [BUS_W-1:0] BUS_B    = 2'd2;
    localparam logic [BUS_W-1:0] BUS_C    = 2'd3;

    // One-hot mask for a channel index, zero when the channel is out of range.
    function automatic logic [NCH-1:0] chan_mask(input logic [CHAN_W-1:0] chan);
        logic [NCH-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (chan == CHAN_W'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/c432.sv
// c432 27-channel priority interrupt core (ISCAS-85), combinational.
// Active-low bus requests gated by E; bus A outranks B outranks C, lowest channel wins.
module c432 (
    input  logic N1,  N4,  N8,  N11, N14, N17, N21, N24, N27,
    input  logic N30, N34, N37, N40, N43, N47, N50, N53, N56,
    input  logic N60, N63, N66, N69, N73, N76, N79, N82, N86,
    input  logic N89, N92, N95, N99, N102, N105, N108, N112, N115,
    output logic N223,
    output logic N329,
    output logic N370,
    output logic N421,
    output logic N430,
    output logic N431,
    output logic N432
);

    logic [8:0] e;
    logic [8:0] a_req;
    logic [8:0] b_req;
    logic [8:0] c_req;
    logic [8:0] sel;
    logic [3:0] chan;

    assign e     = {N108, N95, N82, N69, N56, N43, N30, N17, N4};
    assign a_req = ~{N102, N89, N76, N63, N50, N37, N24, N11, N1}  & e;
    assign b_req = ~{N112, N99, N86, N73, N60, N47, N34, N21, N8}  & e;
    assign c_req = ~{N115, N105, N92, N79, N66, N53, N40, N27, N14} & e;

    assign N223 = |a_req;
    assign N329 = |b_req;
    assign N370 = |c_req;

    assign sel = N223 ? a_req : (N329 ? b_req : c_req);

    // Scan high to low so the lowest requesting channel is the last write.
    always_comb begin
        chan = '0;
        for (int i = 8; i >= 0; i--) begin
            if (sel[i]) chan = 4'(i);
        end
    end

    assign {N421, N430, N431, N432} = chan;

endmodule

// File: rtl/c432_irq_sched.sv
// Sequential interrupt scheduler around one c432 priority core: sticky pending,
// snapshot, fixed settle window, registered vector, clear on acknowledge.
module c432_irq_sched
    import c432_sched_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req_a,
    input  logic [NCH-1:0]   req_b,
    input  logic [NCH-1:0]   req_c,
    input  logic [NCH-1:0]   en,
    input  logic             ack,
    output logic             irq,
    output logic [BUS_W-1:0] irq_bus,
    output logic [CHAN_W-1:0] irq_chan,
    output logic [NCH-1:0]   pend_a,
    output logic [NCH-1:0]   pend_b,
    output logic [NCH-1:0]   pend_c,
    output logic             busy
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("SETTLE_CYC must be in 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [NCH-1:0]    snap_a;
    logic [NCH-1:0]    snap_b;
    logic [NCH-1:0]    snap_c;
    logic [NCH-1:0]    snap_en;
    logic              snap_load;
    logic              do_clear;
    logic              irq_d;
    logic [BUS_W-1:0]  bus_d;
    logic [CHAN_W-1:0] chan_d;
    logic [NCH-1:0]    clr_mask;
    logic [NCH-1:0]    clr_a;
    logic [NCH-1:0]    clr_b;
    logic [NCH-1:0]    clr_c;

    logic              a_vld;
    logic              b_vld;
    logic              c_vld;
    logic [CHAN_W-1:0] core_chan;
    logic [BUS_W-1:0]  bus_sel;

    c432 u_core (
        .N1  (~snap_a[0]), .N11 (~snap_a[1]), .N24 (~snap_a[2]),
        .N37 (~snap_a[3]), .N50 (~snap_a[4]), .N63 (~snap_a[5]),
        .N76 (~snap_a[6]), .N89 (~snap_a[7]), .N102(~snap_a[8]),
        .N8  (~snap_b[0]), .N21 (~snap_b[1]), .N34 (~snap_b[2]),
        .N47 (~snap_b[3]), .N60 (~snap_b[4]), .N73 (~snap_b[5]),
        .N86 (~snap_b[6]), .N99 (~snap_b[7]), .N112(~snap_b[8]),
        .N14 (~snap_c[0]), .N27 (~snap_c[1]), .N40 (~snap_c[2]),
        .N53 (~snap_c[3]), .N66 (~snap_c[4]), .N79 (~snap_c[5]),
        .N92 (~snap_c[6]), .N105(~snap_c[7]), .N115(~snap_c[8]),
        .N4  (snap_en[0]), .N17 (snap_en[1]), .N30 (snap_en[2]),
        .N43 (snap_en[3]), .N56 (snap_en[4]), .N69 (snap_en[5]),
        .N82 (snap_en[6]), .N95 (snap_en[7]), .N108(snap_en[8]),
        .N223(a_vld),
        .N329(b_vld),
        .N370(c_vld),
        .N421(core_chan[3]),
        .N430(core_chan[2]),
        .N431(core_chan[1]),
        .N432(core_chan[0])
    );

    assign bus_sel = a_vld ? BUS_A : (b_vld ? BUS_B : (c_vld ? BUS_C : BUS_NONE));

    // Served-bit clear mask, only live during the CLEAR cycle.
    assign clr_mask = chan_mask(irq_chan);
    assign clr_a    = (do_clear && irq_bus == BUS_A) ? clr_mask : '0;
    assign clr_b    = (do_clear && irq_bus == BUS_B) ? clr_mask : '0;
    assign clr_c    = (do_clear && irq_bus == BUS_C) ? clr_mask : '0;

    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        snap_load  = 1'b0;
        do_clear   = 1'b0;
        irq_d      = irq;
        bus_d      = irq_bus;
        chan_d     = irq_chan;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (|((pend_a | pend_b | pend_c) & en)) begin
                    next_state = EVAL;
                    snap_load  = 1'b1;
                end
            end
            EVAL: begin
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    if (bus_sel != BUS_NONE) begin
                        next_state = SIGNAL;
                        irq_d      = 1'b1;
                        bus_d      = bus_sel;
                        chan_d     = core_chan;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            SIGNAL: begin
                if (ack) next_state = CLEAR;
            end
            CLEAR: begin
                do_clear   = 1'b1;
                irq_d      = 1'b0;
                bus_d      = BUS_NONE;
                chan_d     = '0;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath and output registers; a new request beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            snap_a   <= '0;
            snap_b   <= '0;
            snap_c   <= '0;
            snap_en  <= '0;
            pend_a   <= '0;
            pend_b   <= '0;
            pend_c   <= '0;
            irq      <= 1'b0;
            irq_bus  <= BUS_NONE;
            irq_chan <= '0;
            busy     <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            if (snap_load) begin
                snap_a  <= pend_a;
                snap_b  <= pend_b;
                snap_c  <= pend_c;
                snap_en <= en;
            end
            pend_a   <= (pend_a & ~clr_a) | req_a;
            pend_b   <= (pend_b & ~clr_b) | req_b;
            pend_c   <= (pend_c & ~clr_c) | req_c;
            irq      <= irq_d;
            irq_bus  <= bus_d;
            irq_chan <= chan_d;
            busy     <= (next_state != IDLE);
        end
    end

endmodule
